// File: rtl/color_fsm_driver_if.sv
// Request/response handshake between a sequencer and the Color FSM driver.
// The sequencer side is master; the driver side is slave.
interface color_fsm_driver_if;
  logic req_valid;
  logic req_ready;
  logic req_color;
  logic resp_valid;
  logic resp_err;
  logic resp_ready;

  modport master (
    output req_valid, req_color, resp_ready,
    input  req_ready, resp_valid, resp_err
  );

  modport slave (
    input  req_valid, req_color, resp_ready,
    output req_ready, resp_valid, resp_err
  );
endinterface

// File: rtl/color_fsm_driver.sv
// Drives the Blue/Red Color FSM toward a requested colour with single-cycle toggle
// pulses, checking its state after each pulse, and reports pass/fail.
module color_fsm_driver #(
  parameter int MAX_TRIES = 2,
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  color_fsm_driver_if.slave    bus,
  output logic [1:0]           fsm_cmd,
  input  logic [1:0]           fsm_state,
  output logic [CNT_WIDTH-1:0] toggle_count
);
  localparam int TW = $clog2(MAX_TRIES + 1);
  localparam logic [TW-1:0] TRY_LIM = TW'(MAX_TRIES);

  typedef enum logic [2:0] {IDLE, CHECK, DRIVE, WAIT, RESP} state_t;

  state_t          state_q, state_d;
  logic [1:0]      target_q;
  logic [TW-1:0]   tries_q;
  logic            err_q, err_d;
  logic [1:0]      cmd_d;
  logic            accept, illegal, match;

  assign accept  = (state_q == IDLE) && bus.req_valid;
  // Blue = 2'h1 and Red = 2'h2 are the only legal one-hot encodings.
  assign illegal = (fsm_state[1] == fsm_state[0]);
  assign match   = (fsm_state == target_q);

  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    case (state_q)
      IDLE:  if (accept) state_d = CHECK;
      CHECK: begin
        if (illegal)    begin state_d = RESP; err_d = 1'b1; end
        else if (match) begin state_d = RESP; err_d = 1'b0; end
        else                  state_d = DRIVE;
      end
      DRIVE: state_d = WAIT;
      WAIT: begin
        if (illegal)                  begin state_d = RESP; err_d = 1'b1; end
        else if (match)               begin state_d = RESP; err_d = 1'b0; end
        else if (tries_q == TRY_LIM)  begin state_d = RESP; err_d = 1'b1; end
        else                                state_d = DRIVE;
      end
      RESP:  if (bus.resp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Registered command: high for exactly the cycle spent in DRIVE.
    cmd_d = (state_d == DRIVE) ? 2'h1 : 2'h0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      fsm_cmd      <= 2'h0;
      err_q        <= 1'b0;
      target_q     <= 2'h1;
      tries_q      <= '0;
      toggle_count <= '0;
    end else begin
      state_q <= state_d;
      fsm_cmd <= cmd_d;
      err_q   <= err_d;
      if (accept) begin
        target_q <= bus.req_color ? 2'h2 : 2'h1;
        tries_q  <= '0;
      end
      if (state_q == DRIVE) begin
        tries_q <= tries_q + 1'b1;
        if (~&toggle_count) toggle_count <= toggle_count + 1'b1;
      end
    end
  end

  assign bus.req_ready  = (state_q == IDLE);
  assign bus.resp_valid = (state_q == RESP);
  assign bus.resp_err   = err_q;
endmodule

// File: tb/tb_color_fsm_driver.sv
// Directed bench for color_fsm_driver with a behavioural Color FSM model that can
// be made real (toggling), stuck, or overridden for single cycles.
module tb_color_fsm_driver;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] fsm_cmd, fsm_state;
  logic [1:0] toggle_count;

  color_fsm_driver_if bus();

  color_fsm_driver #(.MAX_TRIES(3), .CNT_WIDTH(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus.slave),
    .fsm_cmd      (fsm_cmd),
    .fsm_state    (fsm_state),
    .toggle_count (toggle_count)
  );

  always #5 clk = ~clk;

  // Color FSM model: toggles Blue<->Red on a toggle command when real_fsm is set.
  logic       load = 1'b0, real_fsm = 1'b0, ovr_en = 1'b0;
  logic [1:0] load_val = 2'h2, ovr_val = 2'h0, model_st = 2'h2;

  always @(posedge clk) begin
    if (load) model_st <= load_val;
    else if (real_fsm && fsm_cmd == 2'h1) model_st <= (model_st == 2'h1) ? 2'h2 : 2'h1;
  end
  assign fsm_state = ovr_en ? ovr_val : model_st;

  int total = 0;
  int bad   = 0;
  int exp_cnt = 0;

  typedef struct {
    logic [1:0] init;
    bit         real_m;
    bit         color;
    int         lat;
    bit         err;
    int         pulses;
  } vec_t;
  vec_t tbl [8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_model(input logic [1:0] v, input bit r);
    load = 1'b1; load_val = v; real_fsm = r;
    step();
    load = 1'b0;
  endtask

  // Starts a request in the current (IDLE) cycle and follows it to the response.
  task automatic run_txn(input string nm, input bit color, input int g_cyc,
                         input logic [1:0] g_val, input int exp_lat, input bit exp_err,
                         input int exp_p, input int stall);
    int   cyc = 0, pulses = 0, lat = -1;
    bit   prev = 0, bad_cmd = 0;
    logic err0;
    bus.req_color = color;
    while (cyc < 30) begin
      bus.req_valid = (cyc == 0);
      ovr_en  = (cyc == g_cyc);
      ovr_val = g_val;
      if (fsm_cmd == 2'h1) begin
        pulses++;
        if (prev) bad_cmd = 1;
        prev = 1;
      end else prev = 0;
      if (fsm_cmd > 2'h1) bad_cmd = 1;
      if (bus.resp_valid) begin
        lat = cyc;
        break;
      end
      step();
      cyc++;
    end
    ovr_en = 1'b0;
    exp_cnt = (exp_cnt + exp_p > 3) ? 3 : exp_cnt + exp_p;
    chk({nm, " latency"}, lat, exp_lat);
    chk({nm, " resp_err"}, bus.resp_err, exp_err);
    chk({nm, " pulses"}, pulses, exp_p);
    chk({nm, " cmd_shape"}, bad_cmd, 0);
    chk({nm, " toggle_count"}, toggle_count, exp_cnt);
    err0 = bus.resp_err;
    for (int i = 0; i < stall; i++) begin
      bus.req_valid = 1'b1;
      bus.resp_ready = 1'b0;
      step();
      chk({nm, " stall resp_valid"}, bus.resp_valid, 1);
      chk({nm, " stall resp_err"}, bus.resp_err, err0);
      chk({nm, " stall req_ready"}, bus.req_ready, 0);
    end
    bus.resp_ready = 1'b1;
    step();
    bus.resp_ready = 1'b0;
    chk({nm, " release resp_valid"}, bus.resp_valid, 0);
    chk({nm, " release req_ready"}, bus.req_ready, 1);
  endtask

  task automatic check_reset_state(input string nm);
    chk({nm, " fsm_cmd"}, fsm_cmd, 0);
    chk({nm, " resp_valid"}, bus.resp_valid, 0);
    chk({nm, " toggle_count"}, toggle_count, 0);
    chk({nm, " req_ready"}, bus.req_ready, 1);
  endtask

  initial begin
    tbl[0] = '{2'h2, 1'b1, 1'b1, 2, 1'b0, 0};
    tbl[1] = '{2'h2, 1'b1, 1'b0, 4, 1'b0, 1};
    tbl[2] = '{2'h1, 1'b1, 1'b1, 4, 1'b0, 1};
    tbl[3] = '{2'h1, 1'b1, 1'b0, 2, 1'b0, 0};
    tbl[4] = '{2'h2, 1'b0, 1'b0, 8, 1'b1, 3};
    tbl[5] = '{2'h1, 1'b0, 1'b1, 8, 1'b1, 3};
    tbl[6] = '{2'h0, 1'b0, 1'b1, 2, 1'b1, 0};
    tbl[7] = '{2'h3, 1'b0, 1'b0, 2, 1'b1, 0};

    bus.req_valid = 1'b0; bus.req_color = 1'b0; bus.resp_ready = 1'b0;
    #2;
    check_reset_state("por");
    chk("por resp_err", bus.resp_err, 0);
    #20 rst = 1'b0;
    step();

    // Stray resp_ready in IDLE must not disturb anything.
    bus.resp_ready = 1'b1;
    step();
    bus.resp_ready = 1'b0;
    chk("stray resp_ready req_ready", bus.req_ready, 1);
    chk("stray resp_ready resp_valid", bus.resp_valid, 0);

    foreach (tbl[i]) begin
      load_model(tbl[i].init, tbl[i].real_m);
      run_txn($sformatf("vec%0d", i), tbl[i].color, -1, 2'h0,
              tbl[i].lat, tbl[i].err, tbl[i].pulses, 0);
    end

    // Glitch during DRIVE is ignored; illegal state during WAIT fails after one pulse.
    load_model(2'h2, 1'b1);
    run_txn("glitch_drive", 1'b0, 2, 2'h0, 4, 1'b0, 1, 0);
    run_txn("illegal_wait", 1'b1, 3, 2'h3, 4, 1'b1, 1, 0);

    // Response back-pressure with a pending request, then that request is taken.
    load_model(2'h2, 1'b1);
    run_txn("stall", 1'b1, -1, 2'h0, 2, 1'b0, 0, 5);
    run_txn("after_stall", 1'b1, -1, 2'h0, 2, 1'b0, 0, 0);

    // Reset during DRIVE.
    load_model(2'h2, 1'b1);
    bus.req_valid = 1'b1; bus.req_color = 1'b0;
    step();
    bus.req_valid = 1'b0;
    step();
    chk("drive cmd", fsm_cmd, 1);
    #1 rst = 1'b1;
    #1 check_reset_state("rst_in_drive");
    #1 rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("post_rst_drive resp_valid", bus.resp_valid, 0);
      chk("post_rst_drive req_ready", bus.req_ready, 1);
    end

    // Reset during WAIT.
    bus.req_valid = 1'b1; bus.req_color = 1'b0;
    step();
    bus.req_valid = 1'b0;
    step();
    step();
    chk("wait cmd", fsm_cmd, 0);
    chk("wait toggle_count", toggle_count, 1);
    #1 rst = 1'b1;
    #1 check_reset_state("rst_in_wait");
    #1 rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("post_rst_wait resp_valid", bus.resp_valid, 0);
      chk("post_rst_wait req_ready", bus.req_ready, 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end
endmodule

// File: doc/color_fsm_driver.md
Name: color_fsm_driver

Overview:
Initiator-side controller for the two-state Color FSM (states Blue/Red). It accepts a "go to colour" request over a valid/ready handshake and drives the FSM's 2-bit command input. It observes the FSM's 2-bit state output, returns a pass/fail response, and counts the toggle commands it has issued. It sits between test/sequencer logic and the Color FSM instance.

Parameters:
MAX_TRIES, 2, maximum toggle pulses per request before failing (>=1)
CNT_WIDTH, 8, width of toggle_count

Ports:
clk  input  1  clock; all state changes on the posedge
rst  input  1  asynchronous reset, active-high
req_valid  input  1  request present
req_ready  output  1  request accepted when req_valid && req_ready at posedge
req_color  input  1  target colour: 0 = Blue, 1 = Red
fsm_cmd  output  2  command to the FSM: 2'h0 = hold, 2'h1 = toggle
fsm_state  input  2  FSM state output: 2'h1 = Blue, 2'h2 = Red; 2'h0 and 2'h3 are illegal
resp_valid  output  1  response present
resp_err  output  1  1 = target not reached or illegal state observed; valid only while resp_valid
resp_ready  input  1  response consumed when resp_valid && resp_ready at posedge
toggle_count  output  CNT_WIDTH  saturating count of toggle pulses issued since reset

Behaviour:
- Reset (async, immediate):
  - state = IDLE; fsm_cmd = 2'h0; resp_valid = 0; resp_err = 0; toggle_count = 0; try counter = 0.
  - req_ready = 1 while in reset and after reset, because the block is in IDLE.
- Target encoding: Blue -> 2'h1, Red -> 2'h2. The target is latched on acceptance.
- fsm_cmd is registered and only ever 2'h0 or 2'h1.
- IDLE:
  - req_ready = 1.
  - On accept: latch the target, clear tries -> CHECK.
- CHECK (one cycle, req_ready = 0):
  - fsm_state illegal -> RESP with err = 1.
  - fsm_state == target -> RESP with err = 0.
  - Otherwise -> DRIVE.
- DRIVE (one cycle):
  - fsm_cmd = 2'h1 during this cycle only.
  - toggle_count += 1, saturating at all-ones.
  - tries += 1.
  - -> WAIT.
- WAIT (one cycle):
  - fsm_cmd = 2'h0.
  - The FSM updated at the edge ending DRIVE, so fsm_state is compared in this cycle.
  - Illegal state -> RESP err = 1.
  - Match -> RESP err = 0.
  - Mismatch and tries == MAX_TRIES -> RESP err = 1.
  - Otherwise -> DRIVE.
- RESP:
  - resp_valid = 1; resp_err is held stable.
  - On resp_ready: resp_valid = 0 at the next edge -> IDLE. req_ready rises in that same next cycle.
- Latency, counting the accept cycle as cycle 0:
  - Already at target: resp_valid in cycle 2.
  - One toggle needed: DRIVE in cycle 2, WAIT in cycle 3, resp_valid in cycle 4.
  - Each additional try adds 2 cycles.
- Boundary conditions:
  - req_valid outside IDLE is ignored; the request is not lost, since the source holds it until req_ready.
  - resp_ready without resp_valid has no effect.
  - fsm_state is sampled only in CHECK and WAIT; glitches in other cycles are ignored.
  - toggle_count saturates and never wraps.
  - tries counter width is clog2(MAX_TRIES+1).
  - rst asserted in any state aborts the operation: no response is issued for the in-flight request, and fsm_cmd returns to 2'h0 immediately.

Test Plan:
1. Reset, FSM model in Red (fsm_state = 2'h2); request Red accepted in cycle 0 -> resp_valid = 1, resp_err = 0 in cycle 2; fsm_cmd stays 2'h0; toggle_count = 0.
2. Real two-state FSM model, request Blue -> exactly one fsm_cmd = 2'h1 pulse in cycle 2; fsm_state = 2'h1 in cycle 3; resp_valid with err = 0 in cycle 4; toggle_count = 1. Then request Red -> second pulse, err = 0, toggle_count = 2.
3. Stuck model (fsm_state fixed at 2'h2), MAX_TRIES = 3, request Blue -> 3 single-cycle pulses separated by hold cycles; resp_err = 1 in cycle 8; toggle_count = 3.
4. fsm_state = 2'h0 during CHECK -> resp_err = 1 in cycle 2 with no toggle pulse. fsm_state = 2'h3 during WAIT -> resp_err = 1 after one pulse.
5. Hold resp_ready = 0 for 5 cycles while req_valid = 1 -> resp_valid and resp_err stable, req_ready = 0, no new accept. On resp_ready = 1: IDLE next cycle and the new request is accepted.
6. Assert rst during WAIT (and separately during DRIVE) -> fsm_cmd = 2'h0, resp_valid = 0, toggle_count = 0 without waiting for an edge; req_ready = 1 after release. With CNT_WIDTH = 2, five toggles -> toggle_count stays 2'h3.
